// File: rtl/miriscv_mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Contents:
//   MDU_XLEN        - datapath width (only 32 is supported)
//   MDU_OP_W        - width of the decoder's MDU operation code
//   mdu_op_e        - MDU operation encoding (MUL..REMU)
//   mdu_div_state_e - iterative divider state (IDLE, ITER, DONE)
//   MDU_DIV_CNT_W   - divider iteration counter width
//   MDU_DIV_ZERO_Q  - quotient returned for a divide by zero
package miriscv_mdu_pkg;

  localparam int MDU_XLEN = 32;
  localparam int MDU_OP_W = 3;

  // Bit 2 marks divide/remainder ops, bit 1 (with bit 2) marks remainder,
  // bit 0 (with bit 2) marks the unsigned variants.
  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } mdu_div_state_e;

  localparam int MDU_DIV_CNT_W = $clog2(MDU_XLEN);

  localparam logic [MDU_XLEN-1:0] MDU_DIV_ZERO_Q = '1;

endpackage

// File: rtl/miriscv_div_iter.sv
// Unsigned radix-2 restoring divider core.
// Ports:
//   clk_i, arst_i  - clock, asynchronous active-high reset
//   start_i        - accept dividend/divisor (only acted on in IDLE)
//   kill_i         - abort; returns to IDLE on the next edge
//   dividend_i     - unsigned dividend
//   divisor_i      - unsigned divisor (non-zero)
//   idle_o         - core is in IDLE
//   busy_o         - core is iterating (ITER)
//   done_o         - quo_o/rem_o hold the final result (DONE)
//   quo_o, rem_o   - quotient and remainder registers
module miriscv_div_iter
  import miriscv_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  mdu_div_state_e           state_q, state_d;
  logic [MDU_DIV_CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]          rem_q, quo_q, div_q;
  logic [XLEN:0]            rem_shift, trial;

  // {rem,quo} shifted left by one; the extra top bit keeps the partial
  // remainder exact when it reaches 2^(XLEN-1) or more.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, div_q};

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = ITER;
        ITER:    if (cnt_q == '0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i && !kill_i) begin
        cnt_q <= MDU_DIV_CNT_W'(XLEN - 1);
        rem_q <= '0;
        quo_q <= dividend_i;
        div_q <= divisor_i;
      end else if (state_q == ITER && !kill_i) begin
        cnt_q <= cnt_q - MDU_DIV_CNT_W'(1);
        // A clear sign bit on the trial means the divisor fits: restore is skipped.
        if (!trial[XLEN]) begin
          rem_q <= trial[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= rem_shift[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign idle_o = (state_q == IDLE);
  assign busy_o = (state_q == ITER);
  assign done_o = (state_q == DONE);
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/miriscv_mdu.sv
// Execute-stage multiply/divide unit.
// Multiplies complete combinationally; divides/remainders use the iterative
// core and stall the pipeline for 33 cycles (result in the 34th cycle).
// Ports:
//   clk_i, arst_i   - clock, asynchronous active-high reset
//   mdu_req_i       - MDU instruction present in execute
//   mdu_op_i        - operation code (mdu_op_e)
//   mdu_port_a_i    - rs1 (multiplicand / dividend)
//   mdu_port_b_i    - rs2 (multiplier / divisor)
//   mdu_kill_i      - pipeline flush, aborts an in-flight divide
//   mdu_stall_o     - stall request to the pipeline
//   mdu_result_o    - result, valid when mdu_req_i=1 and mdu_stall_o=0
module miriscv_mdu
  import miriscv_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                mdu_req_i,
  input  logic [MDU_OP_W-1:0] mdu_op_i,
  input  logic [XLEN-1:0]     mdu_port_a_i,
  input  logic [XLEN-1:0]     mdu_port_b_i,
  input  logic                mdu_kill_i,
  output logic                mdu_stall_o,
  output logic [XLEN-1:0]     mdu_result_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Operation decode
  logic is_div, is_rem, div_signed, a_signed_mul, b_signed_mul;

  assign is_div       = mdu_op_i[2];
  assign is_rem       = mdu_op_i[2] & mdu_op_i[1];
  assign div_signed   = mdu_op_i[2] & ~mdu_op_i[0];
  assign a_signed_mul = (mdu_op_i == MDU_MULH) || (mdu_op_i == MDU_MULHSU);
  assign b_signed_mul = (mdu_op_i == MDU_MULH);

  // Multiply: 33x33 signed product; the low 2*XLEN bits are all that is needed.
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]          mul_res;

  assign mul_a    = {a_signed_mul & mdu_port_a_i[XLEN-1], mdu_port_a_i};
  assign mul_b    = {b_signed_mul & mdu_port_b_i[XLEN-1], mdu_port_b_i};
  assign mul_prod = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
  assign mul_res  = (mdu_op_i == MDU_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // Divide operand preparation and fast-path detection
  logic            b_zero, div_ovf, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;

  assign b_zero  = (mdu_port_b_i == '0);
  assign div_ovf = div_signed && (mdu_port_a_i == INT_MIN) && (mdu_port_b_i == '1);
  assign a_neg   = div_signed & mdu_port_a_i[XLEN-1];
  assign b_neg   = div_signed & mdu_port_b_i[XLEN-1];
  assign a_abs   = a_neg ? -mdu_port_a_i : mdu_port_a_i;
  assign b_abs   = b_neg ? -mdu_port_b_i : mdu_port_b_i;

  logic            div_idle, div_busy, div_done, div_start;
  logic [XLEN-1:0] div_quo, div_rem;

  assign div_start = mdu_req_i && is_div && !b_zero && !div_ovf && !mdu_kill_i && div_idle;

  miriscv_div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .start_i    (div_start),
    .kill_i     (mdu_kill_i),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .idle_o     (div_idle),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  // Result sign flags; both stay 0 for unsigned divides.
  logic quo_neg_q, rem_neg_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (div_start) begin
      quo_neg_q <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
    end
  end

  // Stall is gated by reset so it drops asynchronously mid-divide.
  assign mdu_stall_o = !arst_i && !mdu_kill_i && (div_start || div_busy);

  always_comb begin
    mdu_result_o = '0;
    if (!arst_i && mdu_req_i && !mdu_kill_i) begin
      if (!is_div) begin
        mdu_result_o = mul_res;
      end else if (div_done) begin
        if (is_rem) mdu_result_o = rem_neg_q ? -div_rem : div_rem;
        else        mdu_result_o = quo_neg_q ? -div_quo : div_quo;
      end else if (div_idle) begin
        if (b_zero)       mdu_result_o = is_rem ? mdu_port_a_i : MDU_DIV_ZERO_Q;
        else if (div_ovf) mdu_result_o = is_rem ? '0 : mdu_port_a_i;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_mdu.sv
// Self-checking bench for miriscv_mdu: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_miriscv_mdu;
  import miriscv_mdu_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        mdu_req_i;
  logic [2:0]  mdu_op_i;
  logic [31:0] mdu_port_a_i;
  logic [31:0] mdu_port_b_i;
  logic        mdu_kill_i;
  logic        mdu_stall_o;
  logic [31:0] mdu_result_o;

  int checks = 0;
  int errors = 0;

  localparam int STALL_BUDGET = 40;

  miriscv_mdu dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .mdu_req_i    (mdu_req_i),
    .mdu_op_i     (mdu_op_i),
    .mdu_port_a_i (mdu_port_a_i),
    .mdu_port_b_i (mdu_port_b_i),
    .mdu_kill_i   (mdu_kill_i),
    .mdu_stall_o  (mdu_stall_o),
    .mdu_result_o (mdu_result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      pa, pb, p;
    int          sa, sb;
    int unsigned ua, ub;
    logic [31:0] res;
    sa = int'(a);
    sb = int'(b);
    ua = a;
    ub = b;
    res = '0;
    case (op)
      MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU: begin
        pa = (op == MDU_MULH || op == MDU_MULHSU) ? longint'(sa) : longint'(ua);
        pb = (op == MDU_MULH) ? longint'(sb) : longint'(ub);
        p  = pa * pb;
        res = (op == MDU_MUL) ? p[31:0] : p[63:32];
      end
      MDU_DIV:  res = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      MDU_REM:  res = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      MDU_DIVU: res = (b == 0) ? 32'hFFFF_FFFF : ua / ub;
      MDU_REMU: res = (b == 0) ? a : ua % ub;
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Number of stall cycles a request should produce.
  function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op < 3'd4 || b == 0) return 0;
    if ((op == MDU_DIV || op == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // Issue one request, count stall cycles, check result and stall count.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
    int n;
    @(posedge clk_i);
    #1;
    mdu_req_i    = 1'b1;
    mdu_op_i     = op;
    mdu_port_a_i = a;
    mdu_port_b_i = b;
    n = 0;
    @(negedge clk_i);
    while (mdu_stall_o && n < STALL_BUDGET) begin
      n++;
      @(negedge clk_i);
    end
    check({tag, "_stalls"}, 32'(n), 32'(exp_stall));
    check({tag, "_result"}, mdu_result_o, exp_res);
    @(posedge clk_i);
    #1;
    mdu_req_i = 1'b0;
  endtask

  initial begin
    int          n;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          mode;

    arst_i       = 1'b1;
    mdu_req_i    = 1'b0;
    mdu_op_i     = MDU_MUL;
    mdu_port_a_i = '0;
    mdu_port_b_i = '0;
    mdu_kill_i   = 1'b0;

    #1;
    check("reset_stall", 32'(mdu_stall_o), 32'd0);
    check("reset_result", mdu_result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    check("idle_stall", 32'(mdu_stall_o), 32'd0);
    check("idle_result", mdu_result_o, 32'd0);

    // Multiplies
    run_op("mul_lo",      MDU_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);
    run_op("mulhu_small", MDU_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0);
    run_op("mulh_m1",     MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("mulhsu_m1",   MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhu_max",   MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);

    // Iterative divides
    run_op("div_100_7",   MDU_DIV,  32'd100, 32'd7, 32'd14, 33);
    run_op("rem_100_7",   MDU_REM,  32'd100, 32'd7, 32'd2, 33);
    run_op("rem_m7_2",    MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_m7_2",    MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);

    // Fast paths
    run_op("divu_by0",    MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_by0",    MDU_REMU, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf",     MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",     MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Kill in cycle 10 of a divide
    @(posedge clk_i);
    #1;
    mdu_req_i    = 1'b1;
    mdu_op_i     = MDU_DIV;
    mdu_port_a_i = 32'd100;
    mdu_port_b_i = 32'd7;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    check("kill_pre_stall", 32'(mdu_stall_o), 32'd1);
    @(posedge clk_i);
    #1;
    mdu_kill_i = 1'b1;
    @(negedge clk_i);
    check("kill_stall", 32'(mdu_stall_o), 32'd0);
    check("kill_result", mdu_result_o, 32'd0);
    @(posedge clk_i);
    #1;
    mdu_kill_i = 1'b0;
    mdu_req_i  = 1'b0;
    @(negedge clk_i);
    check("kill_then_idle", 32'(mdu_stall_o), 32'd0);
    run_op("divu_after_kill", MDU_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Request dropped mid-divide: divide still runs to completion
    @(posedge clk_i);
    #1;
    mdu_req_i    = 1'b1;
    mdu_op_i     = MDU_DIVU;
    mdu_port_a_i = 32'd1000;
    mdu_port_b_i = 32'd10;
    repeat (3) @(posedge clk_i);
    #1;
    mdu_req_i = 1'b0;
    n = 3;
    @(negedge clk_i);
    while (mdu_stall_o && n < STALL_BUDGET) begin
      n++;
      @(negedge clk_i);
    end
    check("drop_req_stalls", 32'(n), 32'd33);
    check("drop_req_result", mdu_result_o, 32'd0);

    // Asynchronous reset in cycle 5 of a divide
    @(posedge clk_i);
    #1;
    mdu_req_i    = 1'b1;
    mdu_op_i     = MDU_DIV;
    mdu_port_a_i = 32'd100;
    mdu_port_b_i = 32'd7;
    repeat (5) @(posedge clk_i);
    #1;
    check("rst_pre_stall", 32'(mdu_stall_o), 32'd1);
    arst_i = 1'b1;
    #1;
    check("rst_stall", 32'(mdu_stall_o), 32'd0);
    check("rst_result", mdu_result_o, 32'd0);
    mdu_req_i = 1'b0;
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    check("rst_then_idle", 32'(mdu_stall_o), 32'd0);
    run_op("mul_after_rst", MDU_MUL, 32'd3, 32'd4, 32'd12, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      op   = 3'($urandom_range(7));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(9);
      case (mode)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(15, 1));
        3: a = 32'($urandom_range(100));
        4: b = -32'($urandom_range(15, 1));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_result(op, a, b),
             ref_stalls(op, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
